// File: rtl/step_seq_pkg.sv
// step_seq_pkg: shared state encoding for the step sequencer
package step_seq_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, LOAD = 2'd1, WAIT = 2'd2} state_t;
endpackage

// File: rtl/step_table.sv
// step_table: NSTEPS x CWIDTH duration table, sync write/clear, async read
module step_table #(
  parameter int CWIDTH = 32,
  parameter int NSTEPS = 8,
  parameter int SWIDTH = 3
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_wr_en,
  input  logic [SWIDTH-1:0] i_wr_addr,
  input  logic [CWIDTH-1:0] i_wr_data,
  input  logic [SWIDTH-1:0] i_rd_addr,
  output logic [CWIDTH-1:0] o_rd_data
);
  logic [CWIDTH-1:0] mem_q [NSTEPS];
  logic [CWIDTH-1:0] mem_d [NSTEPS];
  always_comb begin
    mem_d = mem_q;
    if (i_wr_en && int'(i_wr_addr) < NSTEPS) mem_d[i_wr_addr] = i_wr_data;
  end
  always_ff @(posedge i_clk) begin
    if (i_rst) mem_q <= '{default: '0};
    else mem_q <= mem_d;
  end
  assign o_rd_data = int'(i_rd_addr) < NSTEPS ? mem_q[i_rd_addr] : '0;
endmodule

// File: rtl/step_sequencer.sv
// step_sequencer: steps through a duration table, loading a downstream timer per step
module step_sequencer
  import step_seq_pkg::*;
#(
  parameter int CWIDTH = 32,
  parameter int NSTEPS = 8,
  parameter int SWIDTH = 3
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_wr_en,
  input  logic [SWIDTH-1:0] i_wr_addr,
  input  logic [CWIDTH-1:0] i_wr_data,
  input  logic              i_run,
  input  logic [SWIDTH:0]   i_nsteps,
  input  logic              i_loop,
  input  logic              i_abort,
  input  logic              i_done,
  output logic              o_start,
  output logic [CWIDTH-1:0] o_cycles,
  output logic [SWIDTH-1:0] o_step,
  output logic              o_busy,
  output logic              o_step_done,
  output logic              o_fin,
  output logic              o_err
);
  localparam logic [SWIDTH:0] MAX_STEPS = (SWIDTH+1)'(NSTEPS);
  state_t            state_q, state_d;
  logic [SWIDTH-1:0] step_q, step_d;
  logic [SWIDTH:0]   nsteps_q, nsteps_d;
  logic [CWIDTH-1:0] cycles_q, cycles_d, rd_data;
  logic loop_q, loop_d, start_q, start_d, busy_q, busy_d;
  logic step_done_q, step_done_d, fin_q, fin_d, err_q, err_d;
  logic adv, last;
  step_table #(.CWIDTH(CWIDTH), .NSTEPS(NSTEPS), .SWIDTH(SWIDTH)) u_table (
    .i_clk    (i_clk),
    .i_rst    (i_rst),
    .i_wr_en  (i_wr_en && state_q == IDLE),
    .i_wr_addr(i_wr_addr),
    .i_wr_data(i_wr_data),
    .i_rd_addr(step_d),
    .o_rd_data(rd_data)
  );
  assign last = {1'b0, step_q} == nsteps_q - 1'b1;
  always_comb begin
    state_d     = state_q;
    step_d      = step_q;
    nsteps_d    = nsteps_q;
    loop_d      = loop_q;
    step_done_d = 1'b0;
    fin_d       = 1'b0;
    err_d       = 1'b0;
    adv         = 1'b0;
    if (i_abort) state_d = IDLE;
    else
      unique case (state_q)
        IDLE:
          if (i_run) begin
            if (i_nsteps != '0 && i_nsteps <= MAX_STEPS) begin
              nsteps_d = i_nsteps;
              loop_d   = i_loop;
              step_d   = '0;
              state_d  = LOAD;
            end else err_d = 1'b1;
          end
        // a LOAD that raised no start was a zero-length step and completes at once
        LOAD: if (start_q) state_d = WAIT; else adv = 1'b1;
        WAIT: adv = i_done;
        default: state_d = IDLE;
      endcase
    if (adv) begin
      step_done_d = 1'b1;
      fin_d       = last && !loop_q;
      state_d     = fin_d ? IDLE : LOAD;
      step_d      = fin_d ? step_q : last ? '0 : step_q + 1'b1;
    end
  end
  always_comb begin
    start_d  = state_d == LOAD && rd_data != '0;
    cycles_d = state_d == LOAD ? rd_data : cycles_q;
    busy_d   = state_d != IDLE;
  end
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q     <= IDLE;
      step_q      <= '0;
      nsteps_q    <= '0;
      loop_q      <= 1'b0;
      cycles_q    <= '0;
      start_q     <= 1'b0;
      busy_q      <= 1'b0;
      step_done_q <= 1'b0;
      fin_q       <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      step_q      <= step_d;
      nsteps_q    <= nsteps_d;
      loop_q      <= loop_d;
      cycles_q    <= cycles_d;
      start_q     <= start_d;
      busy_q      <= busy_d;
      step_done_q <= step_done_d;
      fin_q       <= fin_d;
      err_q       <= err_d;
    end
  end
  assign o_start     = start_q;
  assign o_cycles    = cycles_q;
  assign o_step      = step_q;
  assign o_busy      = busy_q;
  assign o_step_done = step_done_q;
  assign o_fin       = fin_q;
  assign o_err       = err_q;
endmodule

// File: tb/tb_step_sequencer.sv
// tb_step_sequencer: acts as the downstream timer and checks each step against the table model
module tb_step_sequencer;
  localparam int CW = 32;
  localparam int NS = 8;
  localparam int SW = 3;
  logic i_clk = 1'b0;
  logic i_rst, i_wr_en, i_run, i_loop, i_abort, i_done;
  logic [SW-1:0] i_wr_addr;
  logic [CW-1:0] i_wr_data;
  logic [SW:0]   i_nsteps;
  logic o_start, o_busy, o_step_done, o_fin, o_err;
  logic [CW-1:0] o_cycles;
  logic [SW-1:0] o_step;
  logic [CW-1:0] tbl [NS];
  int n_chk = 0;
  int n_bad = 0;
  step_sequencer #(.CWIDTH(CW), .NSTEPS(NS), .SWIDTH(SW)) dut (
    .i_clk      (i_clk),
    .i_rst      (i_rst),
    .i_wr_en    (i_wr_en),
    .i_wr_addr  (i_wr_addr),
    .i_wr_data  (i_wr_data),
    .i_run      (i_run),
    .i_nsteps   (i_nsteps),
    .i_loop     (i_loop),
    .i_abort    (i_abort),
    .i_done     (i_done),
    .o_start    (o_start),
    .o_cycles   (o_cycles),
    .o_step     (o_step),
    .o_busy     (o_busy),
    .o_step_done(o_step_done),
    .o_fin      (o_fin),
    .o_err      (o_err)
  );
  always #5 i_clk = ~i_clk;
  task automatic check(input string tag, input logic [CW-1:0] got, input logic [CW-1:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic tick;
    @(posedge i_clk);
    #1;
  endtask
  task automatic put(input int a, input logic [CW-1:0] v);
    i_wr_en   = 1'b1;
    i_wr_addr = SW'(a);
    i_wr_data = v;
    tick;
    i_wr_en = 1'b0;
    tbl[a]  = v;
  endtask
  task automatic bad_run(input int n);
    i_run    = 1'b1;
    i_nsteps = (SW+1)'(n);
    tick;
    i_run = 1'b0;
    check("err_pulse", o_err, 1);
    check("err_busy", o_busy, 0);
    check("err_start", o_start, 0);
    tick;
    check("err_clear", o_err, 0);
    check("err_idle", o_busy, 0);
  endtask
  // Expected behaviour: steps visited in order 0..n-1 (wrapping when looping); a non-zero entry
  // loads the timer and waits for done, a zero entry completes on the following clock.
  task automatic run_seq(input int n, input bit lp, input int total);
    int s;
    bit last;
    i_run    = 1'b1;
    i_nsteps = (SW+1)'(n);
    i_loop   = lp;
    tick;
    i_run    = 1'b0;
    i_nsteps = (SW+1)'($urandom);
    i_loop   = 1'($urandom);
    for (int k = 0; k <= total + n; k++) begin
      s = k % n;
      check("busy", o_busy, 1);
      check("step", o_step, s);
      check("start", o_start, tbl[s] != 0);
      if (tbl[s] != 0) check("cycles", o_cycles, tbl[s]);
      if (lp && k == total) begin
        if (tbl[s] != 0 && $urandom % 2 == 1) begin
          tick;
          check("wait_start", o_start, 0);
        end
        i_abort = 1'b1;
        tick;
        i_abort = 1'b0;
        check("abort_busy", o_busy, 0);
        check("abort_start", o_start, 0);
        check("abort_sdone", o_step_done, 0);
        check("abort_fin", o_fin, 0);
        return;
      end
      if (tbl[s] != 0) begin
        i_done = 1'($urandom);
        tick;
        i_done = 1'b0;
        check("wait_start", o_start, 0);
        check("wait_sdone", o_step_done, 0);
        repeat ($urandom % 4) begin
          i_run     = 1'($urandom);
          i_wr_en   = 1'($urandom);
          i_wr_addr = SW'($urandom);
          i_wr_data = $urandom;
          tick;
          check("wait_sdone", o_step_done, 0);
          check("wait_busy", o_busy, 1);
        end
        i_run   = 1'b0;
        i_wr_en = 1'b0;
        i_done  = 1'b1;
        tick;
        i_done = 1'b0;
      end else tick;
      last = s == n - 1;
      check("sdone", o_step_done, 1);
      check("fin", o_fin, last && !lp);
      if (last && !lp) begin
        check("end_busy", o_busy, 0);
        check("end_start", o_start, 0);
        check("end_step", o_step, n - 1);
        return;
      end
    end
    check("seq_overrun", 1, 0);
  endtask
  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
  initial begin
    i_rst = 1'b1; i_wr_en = 1'b0; i_wr_addr = '0; i_wr_data = '0;
    i_run = 1'b0; i_nsteps = '0; i_loop = 1'b0; i_abort = 1'b0; i_done = 1'b0;
    for (int a = 0; a < NS; a++) tbl[a] = '0;
    repeat (2) tick;
    check("rst_busy", o_busy, 0);
    check("rst_start", o_start, 0);
    check("rst_sdone", o_step_done, 0);
    check("rst_fin", o_fin, 0);
    check("rst_err", o_err, 0);
    check("rst_cycles", o_cycles, 0);
    check("rst_step", o_step, 0);
    i_rst = 1'b0;
    tick;
    put(0, 5); put(1, 3); put(2, 7);
    run_seq(3, 0, 0);
    put(0, 4); put(1, 0); put(2, 2);
    run_seq(3, 0, 0);
    put(0, 1); put(1, 1);
    run_seq(2, 1, 6);
    bad_run(0);
    bad_run(9);
    i_done = 1'b1;
    tick;
    i_done = 1'b0;
    check("idle_done_sdone", o_step_done, 0);
    check("idle_done_start", o_start, 0);
    check("idle_done_busy", o_busy, 0);
    put(0, 9);
    i_run = 1'b1; i_nsteps = 1; i_loop = 1'b0;
    tick;
    i_run = 1'b0;
    tick;
    check("pre_rst_busy", o_busy, 1);
    i_rst = 1'b1;
    i_done = 1'b1;
    tick;
    i_rst = 1'b0;
    check("mid_rst_busy", o_busy, 0);
    check("mid_rst_cycles", o_cycles, 0);
    check("mid_rst_sdone", o_step_done, 0);
    tick;
    i_done = 1'b0;
    check("post_rst_sdone", o_step_done, 0);
    check("post_rst_busy", o_busy, 0);
    for (int a = 0; a < NS; a++) tbl[a] = '0;
    run_seq(8, 0, 0);
    run_seq(3, 1, 7);
    repeat (40) begin
      int n;
      for (int a = 0; a < NS; a++)
        put(a, $urandom % 3 == 0 ? '0 : ($urandom % 2 == 1 ? CW'($urandom_range(1, 50)) : CW'($urandom)));
      n = $urandom_range(1, NS);
      if ($urandom % 4 == 0) run_seq(n, 1, $urandom_range(1, 2 * n));
      else run_seq(n, 0, 0);
    end
    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end
endmodule
